// File: rtl/mux_stream_arb_if.sv
// Stream bundle between NUM_CH producers, the arbiter and one downstream consumer.
// The slave modport is the arbiter's view; master is the surrounding producer/consumer view.
interface mux_stream_arb_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mux_stream_arb.sv
// NUM_CH:1 streaming mux with a registered output stage.
// Each cycle it grants either the channel picked by sel or the next valid channel in round-robin order.
module mux_stream_arb #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode,
    input  logic [$clog2(NUM_CH)-1:0]  sel,
    mux_stream_arb_if.slave            bus
);
    localparam int SEL_W = $clog2(NUM_CH);
    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]  rr_ptr;
    logic [DATA_W-1:0] out_data_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              out_valid_q;

    logic              can_load;
    logic              grant_valid;
    logic [SEL_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic              transfer;
    logic [SEL_W:0]    cand_wide;
    logic [SEL_W-1:0]  cand;

    assign can_load = !out_valid_q || bus.out_ready;

    // No grant is issued while reset is held, so in_ready stays all-zero during reset.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_wide   = '0;
        cand        = '0;
        if (rst_n) begin
            if (!mode) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (sel == SEL_W'(i) && bus.in_valid[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = SEL_W'(i);
                    end
                end
            end else begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    cand_wide = {1'b0, rr_ptr} + (SEL_W+1)'(k);
                    if (cand_wide >= NUM_CH_W) begin
                        cand_wide = cand_wide - NUM_CH_W;
                    end
                    cand = cand_wide[SEL_W-1:0];
                    if (!grant_valid && bus.in_valid[cand]) begin
                        grant_valid = 1'b1;
                        grant_idx   = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.in_ready[i] = can_load && grant_valid && (grant_idx == SEL_W'(i));
        end
    end

    assign transfer = can_load && grant_valid;

    // A drain and a new load in the same cycle keep out_valid high for full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (transfer) begin
            out_data_q  <= grant_data;
            out_ch_q    <= grant_idx;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // The pointer only advances on round-robin grants; static mode leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= LAST_CH;
        end else if (transfer && mode) begin
            rr_ptr <= grant_idx;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.in_ready));
endmodule

// File: tb/tb_mux_stream_arb.sv
// Directed bench for mux_stream_arb with hand-computed expectations for round-robin,
// static select, backpressure and asynchronous reset.
module tb_mux_stream_arb;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    int         checks;
    int         errors;

    mux_stream_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    mux_stream_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic m, input logic [1:0] s,
                                 input logic [3:0] v, input logic r);
        mode          = m;
        sel           = s;
        bus.in_valid  = v;
        bus.out_ready = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic setData(input int ch, input logic [31:0] d);
        bus.in_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rr_data [5];
    logic [31:0] rr_ch   [5];
    logic [3:0]  rr_rdy  [5];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) setData(i, 32'hA0 + i);
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        repeat (3) step();

        checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset_in_ready", {28'd0, bus.in_ready}, 32'd0);
        checkOutput("reset_out_data", bus.out_data, 32'd0);
        checkOutput("reset_out_ch", {30'd0, bus.out_ch}, 32'd0);

        rst_n = 1'b1;
        #1;
        checkOutput("first_grant_rdy", {28'd0, bus.in_ready}, 32'h1);

        rr_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
        rr_ch   = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        rr_rdy  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("rr_valid", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("rr_data", bus.out_data, rr_data[i]);
            checkOutput("rr_ch", {30'd0, bus.out_ch}, rr_ch[i]);
            checkOutput("rr_rdy", {28'd0, bus.in_ready}, {28'd0, rr_rdy[i]});
        end

        // rr_ptr is 0 here, so the sparse pattern starts at ch1.
        applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1);
        checkOutput("sparse_rdy0", {28'd0, bus.in_ready}, 32'h2);
        rr_data = '{32'hA1, 32'hA3, 32'hA1, 32'h0, 32'h0};
        rr_ch   = '{32'd1, 32'd3, 32'd1, 32'd0, 32'd0};
        rr_rdy  = '{4'b1000, 4'b0010, 4'b1000, 4'b0, 4'b0};
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("sparse_data", bus.out_data, rr_data[i]);
            checkOutput("sparse_ch", {30'd0, bus.out_ch}, rr_ch[i]);
            checkOutput("sparse_rdy", {28'd0, bus.in_ready}, {28'd0, rr_rdy[i]});
            checkOutput("sparse_rdy_masked", {28'd0, bus.in_ready & 4'b0101}, 32'd0);
        end

        setData(2, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1);
        checkOutput("static_rdy", {28'd0, bus.in_ready}, 32'h4);
        step();
        checkOutput("static_data", bus.out_data, 32'hDEADBEEF);
        checkOutput("static_ch", {30'd0, bus.out_ch}, 32'd2);
        applyStimulus(1'b0, 2'd2, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_rdy", {28'd0, bus.in_ready}, 32'd0);
            step();
            checkOutput("stall_data", bus.out_data, 32'hDEADBEEF);
            checkOutput("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        setData(2, 32'h12345678);
        applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1);
        checkOutput("drain_load_rdy", {28'd0, bus.in_ready}, 32'h4);
        step();
        checkOutput("drain_load_data", bus.out_data, 32'h12345678);
        checkOutput("drain_load_valid", {31'd0, bus.out_valid}, 32'd1);

        applyStimulus(1'b0, 2'd1, 4'b1101, 1'b1);
        checkOutput("nosel_rdy", {28'd0, bus.in_ready}, 32'd0);
        step();
        checkOutput("nosel_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("nosel_hold_data", bus.out_data, 32'h12345678);
        step();
        checkOutput("nosel_valid2", {31'd0, bus.out_valid}, 32'd0);
        applyStimulus(1'b0, 2'd1, 4'b1111, 1'b1);
        checkOutput("sel1_rdy", {28'd0, bus.in_ready}, 32'h2);
        applyStimulus(1'b0, 2'd1, 4'b1111, 1'b1);
        step();
        checkOutput("sel1_ch", {30'd0, bus.out_ch}, 32'd1);
        checkOutput("sel1_data", bus.out_data, 32'hA1);
        applyStimulus(1'b0, 2'd1, 4'b0000, 1'b1);
        step();
        checkOutput("sel1_drained", {31'd0, bus.out_valid}, 32'd0);

        // rr_ptr was left at 1; a restored pointer makes the first round-robin grant ch0.
        applyStimulus(1'b0, 2'd0, 4'b0001, 1'b1);
        step();
        checkOutput("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        applyStimulus(1'b0, 2'd0, 4'b0000, 1'b0);
        step();
        checkOutput("pre_rst_stall", {31'd0, bus.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("async_rst_data", bus.out_data, 32'd0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        checkOutput("post_rst_rdy", {28'd0, bus.in_ready}, 32'h1);
        step();
        checkOutput("post_rst_ch", {30'd0, bus.out_ch}, 32'd0);
        checkOutput("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_stream_arb.md
Name: mux_stream_arb

Overview:
- Parametrised successor to the team's 4:1 32-bit combinational mux.
- Selects one of NUM_CH streaming inputs onto a single registered output with a valid/ready handshake.
- Two run-time modes: static select, or round-robin arbitration among valid channels.
- Sits between neuron-layer producers and a shared accumulator/bus; replaces combinational select where backpressure is needed.

Parameters:
- NUM_CH, 4, number of input channels (>=2); SEL_W = $clog2(NUM_CH) is a derived localparam.
- DATA_W, 32, data width per channel.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = static select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used in mode 0.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; at most one bit high.
- out_data  output  DATA_W  registered data.
- out_ch  output  SEL_W  source channel of the current out_data.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1. in_ready is combinational and therefore all-zero while out_valid is held low, because no grant is issued in reset.
- can_load = !out_valid || out_ready. The output register accepts a new beat when can_load is true.
- Grant, computed combinationally each cycle:
  - mode 0: grant channel sel if in_valid[sel]=1; otherwise no grant. sel values >= NUM_CH give no grant.
  - mode 1: first channel with in_valid=1, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH; no grant if none are valid.
- in_ready[g] = can_load && granted(g); all other in_ready bits are 0. in_ready must not depend on in_valid of non-granted channels beyond the grant logic.
- Transfer on input i occurs when in_valid[i] && in_ready[i]. At the next clock edge: out_data <= channel i data, out_ch <= i, out_valid <= 1.
- If out_valid && out_ready and no transfer occurs: out_valid <= 0. out_data and out_ch hold their last value.
- Simultaneous output drain and new transfer in the same cycle: new beat loaded and out_valid stays 1, giving full throughput of 1 beat/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- While out_valid=1 and out_ready=0, out_data, out_ch and out_valid hold stable. No overwrite, no drop.
- rr_ptr <= granted index on each transfer, in mode 1 only. rr_ptr is untouched in mode 0.
- Wrap-around: after a grant to NUM_CH-1, the search starts at channel 0.
- mode or sel changes take effect on the next arbitration. A beat already held in the output register is unaffected.
- No combinational path from in_valid to out_valid. The only combinational paths are out_ready to in_ready and in_valid/sel/mode to in_ready.
- Reset asserted mid-stream: the held beat is discarded, out_valid drops immediately (async), and rr_ptr is restored.
- Assertion: the in_ready vector is one-hot or zero.

Test Plan:
- Reset/idle: hold rst_n=0, drive in_valid=4'b1111 -> out_valid=0, in_ready=0. Release reset, mode=1 -> first grant is ch0 (in_ready=4'b0001) and out_ch=0 one cycle later.
- Round-robin fairness: mode=1, in_valid=4'b1111 constant, out_ready=1, data = 0xA0+ch -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles, out_ch 0,1,2,3,0.
- Sparse round-robin skip: mode=1, in_valid=4'b1010 -> grants alternate ch1, ch3, ch1. Channels 0 and 2 never get in_ready.
- Static mode and backpressure: mode=0, sel=2, in_data ch2=0xDEADBEEF, out_ready=0 for 3 cycles -> out_data=0xDEADBEEF held, out_valid=1, in_ready=0 throughout. Raise out_ready -> next ch2 beat loads the same cycle the held beat drains.
- Static select with invalid channel: mode=0, sel=1, in_valid=4'b1101 -> no grant, out_valid stays 0. Set in_valid[1]=1 -> one beat passes with out_ch=1.
- Async reset mid-operation: out_valid=1 and stalled, pulse rst_n low between clock edges -> out_valid=0 immediately. After release, mode=1 grants ch0 first.
